calc_key_entry: RTL and testbench

// Keypad front-end directly upstream of the calculator datapath. Accepts one key code per

---
 rtl/calc_key_entry_if.sv | 21 ++
 rtl/calc_key_entry.sv | 132 +++++++++++++
 tb/tb_calc_key_entry.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_key_entry_if.sv
// Keypad handshake, calculator request bus and the calculator's flag return,
// bundled as a single interface for calc_key_entry.
interface calc_key_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        inf_fb;
  logic        ovf_fb;
  logic [54:0] calc_bus;
  logic        busy;

  modport master (
    output key_valid, key_code, inf_fb, ovf_fb,
    input  key_ready, calc_bus, busy
  );

  modport slave (
    input  key_valid, key_code, inf_fb, ovf_fb,
    output key_ready, calc_bus, busy
  );
endinterface

// File: rtl/calc_key_entry.sv
// Keypad front-end: builds BCD operand A, operator and operand B, and issues a
// toggle-based request to the calculator on '=' while capturing its error flags.
//
// state  | meaning
// S_A    | entering operand A
// S_OP   | operator chosen, B still blank
// S_B    | entering operand B
// S_CAP  | one-cycle capture of calculator inf/ovf after req_tgl flip
// S_DONE | result shown, bus frozen until a digit or clear
module calc_key_entry (
  input  logic           clk,
  input  logic           rst_n,
  calc_key_entry_if.slave kif
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [23:0] BLANK = 24'hFFFFFF;

  state_t      state;
  logic [23:0] a_q;
  logic [23:0] b_q;
  logic [3:0]  op_q;
  logic        req_q;
  logic        inf_q;
  logic        ovf_q;
  logic        ready_q;
  logic        busy_q;

  logic fire;
  logic is_digit;
  logic is_op;
  logic is_eq;
  logic is_clr;

  assign fire     = kif.key_valid & ready_q;
  assign is_digit = (kif.key_code <= 4'd9);
  assign is_op    = (kif.key_code >= 4'hA) && (kif.key_code <= 4'hD);
  assign is_eq    = (kif.key_code == 4'hE);
  assign is_clr   = (kif.key_code == 4'hF);

  assign kif.calc_bus  = {ovf_q, inf_q, req_q, op_q, a_q, b_q};
  assign kif.key_ready = ready_q;
  assign kif.busy      = busy_q;

  // A lone leading zero is replaced rather than shifted; a full field drops the digit.
  function automatic logic [23:0] push_digit(input logic [23:0] f, input logic [3:0] d);
    if (f == 24'hFFFFF0)
      return {20'hFFFFF, d};
    else if (f[23:20] != 4'hF)
      return f;
    else
      return {f[19:0], d};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_A;
      a_q     <= BLANK;
      b_q     <= BLANK;
      op_q    <= 4'h0;
      req_q   <= 1'b0;
      inf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state == S_CAP) begin
      inf_q   <= kif.inf_fb;
      ovf_q   <= kif.ovf_fb;
      state   <= S_DONE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      if (fire) begin
        if (is_clr) begin
          // req_tgl/inf/ovf are left alone so the calculator handshake stays in step
          a_q   <= BLANK;
          b_q   <= BLANK;
          op_q  <= 4'h0;
          state <= S_A;
        end else begin
          case (state)
            S_A: begin
              if (is_digit) begin
                a_q <= push_digit(a_q, kif.key_code);
              end else if (is_op && (a_q[3:0] != 4'hF)) begin
                op_q  <= kif.key_code;
                state <= S_OP;
              end
            end
            S_OP: begin
              if (is_op) begin
                op_q <= kif.key_code;
              end else if (is_digit) begin
                b_q   <= push_digit(b_q, kif.key_code);
                state <= S_B;
              end
            end
            S_B: begin
              if (is_digit) begin
                b_q <= push_digit(b_q, kif.key_code);
              end else if (is_eq) begin
                req_q   <= ~req_q;
                state   <= S_CAP;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end
            S_DONE: begin
              if (is_digit) begin
                a_q   <= {20'hFFFFF, kif.key_code};
                b_q   <= BLANK;
                op_q  <= 4'h0;
                state <= S_A;
              end
            end
            default: state <= S_A;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: stimulus pushes hand-computed bus images into a
// queue, a monitor pops and compares on every accepted key and every capture cycle.
module tb_calc_key_entry;

  typedef struct {
    logic [54:0] bus;
    logic        busy;
    logic        ready;
    string       name;
  } exp_t;

  localparam logic [23:0] F6 = 24'hFFFFFF;

  logic clk;
  logic rst_n;
  calc_key_entry_if ifc ();

  calc_key_entry dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (ifc)
  );

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_wait;
  logic exp_req, exp_inf, exp_ovf;
  logic mon_fire, mon_cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [54:0] mk(input logic ovf, input logic inf, input logic req,
                                     input logic [3:0] op, input logic [23:0] a,
                                     input logic [23:0] b);
    return {ovf, inf, req, op, a, b};
  endfunction

  always @(posedge clk) begin
    mon_fire = ifc.key_valid && ifc.key_ready;
    mon_cap  = ifc.busy;
    if (mon_fire || mon_cap) begin
      exp_t e;
      #1;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event bus=%h busy=%b ready=%b required no event",
                 ifc.calc_bus, ifc.busy, ifc.key_ready);
      end else begin
        e = q.pop_front();
        if (ifc.calc_bus !== e.bus || ifc.busy !== e.busy || ifc.key_ready !== e.ready) begin
          n_fail++;
          $display("FAIL %s bus=%h busy=%b ready=%b required bus=%h busy=%b ready=%b",
                   e.name, ifc.calc_bus, ifc.busy, ifc.key_ready, e.bus, e.busy, e.ready);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [54:0] act, input logic [54:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic wait_ready(input string nm, output bit ok);
    ok = 1'b1;
    last_wait = 0;
    while (!ifc.key_ready && last_wait < 20) begin
      @(negedge clk);
      last_wait++;
    end
    if (!ifc.key_ready) begin
      ok = 1'b0;
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout key_ready=0 required 1", nm);
      ifc.key_valid = 1'b0;
    end
  endtask

  task automatic press(input logic [3:0] c, input logic [3:0] eop, input logic [23:0] ea,
                       input logic [23:0] eb, input string nm);
    bit ok;
    @(negedge clk);
    ifc.key_valid = 1'b1;
    ifc.key_code  = c;
    wait_ready(nm, ok);
    if (ok) begin
      q.push_back('{mk(exp_ovf, exp_inf, exp_req, eop, ea, eb), 1'b0, 1'b1, nm});
      @(posedge clk);
    end
  endtask

  // '=' in S_B: accept cycle (busy, req flipped) then capture cycle (flags loaded)
  task automatic eq(input logic [3:0] eop, input logic [23:0] ea, input logic [23:0] eb,
                    input logic fbi, input logic fbo, input bit rst_in_cap, input string nm);
    bit ok;
    @(negedge clk);
    ifc.key_valid = 1'b1;
    ifc.key_code  = 4'hE;
    ifc.inf_fb    = fbi;
    ifc.ovf_fb    = fbo;
    wait_ready(nm, ok);
    if (ok) begin
      exp_req = ~exp_req;
      q.push_back('{mk(exp_ovf, exp_inf, exp_req, eop, ea, eb), 1'b1, 1'b0, {nm, "_acc"}});
      if (rst_in_cap) begin
        exp_req = 1'b0; exp_inf = 1'b0; exp_ovf = 1'b0;
        q.push_back('{mk(0, 0, 0, 4'h0, F6, F6), 1'b0, 1'b0, {nm, "_rst"}});
      end else begin
        exp_inf = fbi;
        exp_ovf = fbo;
        q.push_back('{mk(exp_ovf, exp_inf, exp_req, eop, ea, eb), 1'b0, 1'b1, {nm, "_cap"}});
      end
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifc.key_valid = 1'b0;
    ifc.key_code  = 4'h0;
    ifc.inf_fb    = 1'b0;
    ifc.ovf_fb    = 1'b0;
    exp_req = 1'b0; exp_inf = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_bus", ifc.calc_bus, mk(0, 0, 0, 4'h0, F6, F6));
    chk("reset_ready", {54'd0, ifc.key_ready}, 55'd0);
    chk("reset_busy", {54'd0, ifc.busy}, 55'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {54'd0, ifc.key_ready}, 55'd1);

    // 12 + 3 =
    press(4'h1, 4'h0, 24'hFFFFF1, F6, "t1_d1");
    press(4'h2, 4'h0, 24'hFFFF12, F6, "t1_d2");
    press(4'hD, 4'hD, 24'hFFFF12, F6, "t1_add");
    press(4'h3, 4'hD, 24'hFFFF12, 24'hFFFFF3, "t1_b3");
    eq(4'hD, 24'hFFFF12, 24'hFFFFF3, 1'b0, 1'b0, 1'b0, "t1_eq");

    // seven digits, the last one dropped; '=' in S_A ignored
    press(4'hF, 4'h0, F6, F6, "t2_clr");
    press(4'h1, 4'h0, 24'hFFFFF1, F6, "t2_d1");
    press(4'h2, 4'h0, 24'hFFFF12, F6, "t2_d2");
    press(4'h3, 4'h0, 24'hFFF123, F6, "t2_d3");
    press(4'h4, 4'h0, 24'hFF1234, F6, "t2_d4");
    press(4'h5, 4'h0, 24'hF12345, F6, "t2_d5");
    press(4'h6, 4'h0, 24'h123456, F6, "t2_d6");
    press(4'h7, 4'h0, 24'h123456, F6, "t2_d7_dropped");
    press(4'hE, 4'h0, 24'h123456, F6, "t2_eq_in_a");

    // leading zeros, operator replacement, '=' in S_OP ignored
    press(4'hF, 4'h0, F6, F6, "t3_clr");
    press(4'h0, 4'h0, 24'hFFFFF0, F6, "t3_z1");
    press(4'h0, 4'h0, 24'hFFFFF0, F6, "t3_z2");
    press(4'h5, 4'h0, 24'hFFFFF5, F6, "t3_d5");
    press(4'hD, 4'hD, 24'hFFFFF5, F6, "t3_add");
    press(4'hB, 4'hB, 24'hFFFFF5, F6, "t3_mul_replace");
    press(4'hE, 4'hB, 24'hFFFFF5, F6, "t3_eq_in_op");

    // operator on empty A ignored; no chaining in S_B; inf captured, then held
    press(4'hF, 4'h0, F6, F6, "t4_clr");
    press(4'hD, 4'h0, F6, F6, "t4_op_empty_a");
    press(4'h9, 4'h0, 24'hFFFFF9, F6, "t4_d9");
    press(4'hA, 4'hA, 24'hFFFFF9, F6, "t4_div");
    press(4'h0, 4'hA, 24'hFFFFF9, 24'hFFFFF0, "t4_b0");
    press(4'hD, 4'hA, 24'hFFFFF9, 24'hFFFFF0, "t4_no_chain");
    eq(4'hA, 24'hFFFFF9, 24'hFFFFF0, 1'b1, 1'b0, 1'b0, "t4_eq");
    press(4'hF, 4'h0, F6, F6, "t4_clr_keeps_flags");
    press(4'h9, 4'h0, 24'hFFFFF9, F6, "t4b_d9");
    press(4'hA, 4'hA, 24'hFFFFF9, F6, "t4b_div");
    press(4'h0, 4'hA, 24'hFFFFF9, 24'hFFFFF0, "t4b_b0");
    eq(4'hA, 24'hFFFFF9, 24'hFFFFF0, 1'b1, 1'b0, 1'b0, "t4b_eq");

    // key held through S_CAP, then digit in S_DONE restarts; clear mid-B
    press(4'h4, 4'h0, 24'hFFFFF4, F6, "t5_done_digit");
    chk("t5_hold_wait_cycles", 55'(last_wait), 55'd1);
    press(4'hB, 4'hB, 24'hFFFFF4, F6, "t5_mul");
    press(4'h2, 4'hB, 24'hFFFFF4, 24'hFFFFF2, "t5_b2");
    press(4'hF, 4'h0, F6, F6, "t5_clr_mid_b");

    // ovf capture, frozen bus in S_DONE
    press(4'h8, 4'h0, 24'hFFFFF8, F6, "t6_d8");
    press(4'hC, 4'hC, 24'hFFFFF8, F6, "t6_sub");
    press(4'h1, 4'hC, 24'hFFFFF8, 24'hFFFFF1, "t6_b1");
    eq(4'hC, 24'hFFFFF8, 24'hFFFFF1, 1'b0, 1'b1, 1'b0, "t6_eq");
    press(4'hD, 4'hC, 24'hFFFFF8, 24'hFFFFF1, "t6_done_op_ignored");
    press(4'hE, 4'hC, 24'hFFFFF8, 24'hFFFFF1, "t6_done_eq_ignored");

    // reset mid-entry
    press(4'hF, 4'h0, F6, F6, "t7_clr");
    press(4'h1, 4'h0, 24'hFFFFF1, F6, "t7_d1");
    press(4'h2, 4'h0, 24'hFFFF12, F6, "t7_d2");
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    exp_req = 1'b0; exp_inf = 1'b0; exp_ovf = 1'b0;
    chk("t7_reset_mid_entry", ifc.calc_bus, mk(0, 0, 0, 4'h0, F6, F6));
    rst_n = 1'b1;
    @(negedge clk);

    // reset during S_CAP: no flag capture, req_tgl back to 0
    press(4'h3, 4'h0, 24'hFFFFF3, F6, "t8_d3");
    press(4'hD, 4'hD, 24'hFFFFF3, F6, "t8_add");
    press(4'h3, 4'hD, 24'hFFFFF3, 24'hFFFFF3, "t8_b3");
    eq(4'hD, 24'hFFFFF3, 24'hFFFFF3, 1'b1, 1'b1, 1'b1, "t8_eq");
    @(negedge clk);
    rst_n = 1'b0;
    ifc.key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t8_after_cap_reset", ifc.calc_bus, mk(0, 0, 0, 4'h0, F6, F6));

    // fresh request after reset toggles from 0
    press(4'h6, 4'h0, 24'hFFFFF6, F6, "t9_d6");
    press(4'hB, 4'hB, 24'hFFFFF6, F6, "t9_mul");
    press(4'h7, 4'hB, 24'hFFFFF6, 24'hFFFFF7, "t9_b7");
    eq(4'hB, 24'hFFFFF6, 24'hFFFFF7, 1'b0, 1'b0, 1'b0, "t9_eq");
    idle();
    repeat (4) @(negedge clk);
    chk("queue_drained", 55'(q.size()), 55'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
